ts_pid_capture: RTL
===================

Name: ts_pid_capture

Overview:
- Receive-side counterpart of the TS packet replacer: the replacer writes packet contents into the MPEG byte stream, this block reads them back out.
- Monitors a 188-byte MPEG-TS byte stream and filters packets against a programmable PID table.
- Captures up to CAPTURE_GROUPS whole matching packets into a word-packed buffer; the AXI register side then reads the buffer by word index.
- Used to retrieve template packets (PAT/PMT/PES headers) that the replacer later reinjects.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, register/buffer word width; only 32 is supported.
- MATCH_PID_COUNT, 4, number of PID filter slots.
- CAPTURE_GROUPS, 2, number of 188-byte packets held per capture run.

Ports:
- clk  in  1  single clock; stream and register side are synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- mpeg_data  in  8  TS byte.
- mpeg_valid  in  1  byte qualifier.
- mpeg_sync  in  1  marks the first byte of a packet; qualified by mpeg_valid.
- update_pid_request  in  1  one-cycle write strobe for the PID table.
- pid_index  in  32  PID slot index, used for both write and readback.
- pid  in  32  [12:0] PID value, [16] match enable, all other bits ignored.
- out_pid  out  32  combinational readback of slot pid_index in the same format; returns 0 when the index is out of range.
- capture_request  in  1  one-cycle pulse that arms a capture run.
- capture_busy  out  1  high while a run is armed or capturing.
- capture_ready  out  1  high when a run has completed.
- captured_count  out  32  packets stored in the current or last run.
- read_index  in  32  buffer word index, 0..47*CAPTURE_GROUPS-1.
- read_data  out  32  buffer word; 1-cycle latency.
- matched_count  out  32  free-running count of matched packet headers.

Behaviour:
- Reset values: all outputs 0; PID table cleared (all slots disabled); FSM in IDLE. Buffer contents are not reset.
- PID table write: when update_pid_request=1 and pid_index<MATCH_PID_COUNT, the slot is written on that clock edge. Out-of-range writes are ignored.
- Byte order: packet byte n of group g goes to word g*47+n/4, bits [8*(n%4)+7 -: 8].
- Byte counter: a valid byte with mpeg_sync=1 and data 8'h47 sets byte_idx=0. Every other valid byte increments byte_idx, saturating at 188. Bytes with byte_idx≥188 are discarded.
- PID: formed as {byte1[4:0], byte2}, evaluated on the valid byte at byte_idx 2. A hit requires any enabled slot to equal the PID; multiple hits count as one.
- matched_count: increments on every hit, whatever the FSM state.
- FSM states:
  - IDLE: capture_request → ARMED; captured_count<=0; capture_ready<=0; capture_busy<=1.
  - ARMED: a valid sync byte 0x47 → HDR. Byte 0 is written speculatively into slot captured_count.
  - HDR: bytes 1 and 2 are written speculatively. At byte 2 a hit → CAP, a miss → ARMED (the slot is reused by the next packet).
  - CAP: writes bytes 3..187. The write of byte 187 increments captured_count. If captured_count then equals CAPTURE_GROUPS → DONE, otherwise → ARMED.
  - DONE: capture_ready<=1, capture_busy<=0 → IDLE. capture_ready holds until the next capture_request.
- Word assembly: bytes accumulate in a 32-bit shift register. The RAM write fires on byte%4==3, so byte 187 completes word 46.
- Short packet (sync 0x47 arrives in HDR or CAP before byte 187): the partial slot is abandoned, captured_count is unchanged, and the new byte restarts as byte 0 in HDR.
- A sync flag with a data byte other than 0x47 is treated as a normal byte.
- capture_request while busy is ignored. A sync byte on the same cycle as capture_request is not captured; arming takes effect on the next cycle.
- read_data <= buf[read_index] for in-range indices, otherwise 0. Reads are permitted at any time; data is only guaranteed while capture_ready=1.
- Reset asserted mid-run: immediate return to IDLE with all outputs at 0.

Decomposition:
- Shared package ts_pkg:
  - TS_PACK_BYTE_SIZE=188, TS_PACK_WORD_SIZE=47, TS_SYNC_BYTE=8'h47.
  - PID field offsets (PID [12:0], enable bit 16).
  - Capture FSM state enum.
- Sub-module ts_pid_filter: the PID table plus parallel compare, producing a hit output. It is natural to share it with the replacer.

Test Plan:
- Slot 0 written with PID 0x100 enabled; stream of PIDs 0x011, 0x100, 0x100 → capture_ready after the 3rd packet, captured_count=2, matched_count=2; word 0 = {byte3,0x00,0x41,0x47} for header 47 41 00 xx; word 47 is the second packet's first word.
- Only disabled slots programmed (pid bit16=0); stream of 0x100 → capture_busy stays 1, matched_count=0, captured_count=0.
- Matching packet cut at byte 100 by a new 0x47 sync, followed by 2 full matching packets → captured_count=2; buffer holds only the full packets; group 0 word 0 is the first full packet's header.
- mpeg_valid toggled 50% random during capture → buffer contents identical to the gap-free run.
- capture_request pulsed mid-run → ignored. rst_n dropped at byte 60 of packet 2 → all outputs 0 asynchronously; after release, out_pid of slot 0 reads 0.
- read_index=94 (out of range for CAPTURE_GROUPS=2) → read_data=0 one cycle later. update_pid_request with pid_index=4 → no slot changes.

Source files
------------

// File: rtl/ts_pkg.sv
// ts_pkg: constants and types shared by the TS capture path.
//   Packet geometry (188 bytes / 47 words), sync byte value,
//   PID register field layout ([12:0] PID, [16] enable) and the capture FSM states.
package ts_pkg;
    localparam int         TS_PACK_BYTE_SIZE = 188;
    localparam int         TS_PACK_WORD_SIZE = 47;
    localparam logic [7:0] TS_SYNC_BYTE      = 8'h47;

    localparam int PID_W      = 13;
    localparam int PID_LSB    = 0;
    localparam int PID_MSB    = 12;
    localparam int PID_EN_BIT = 16;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_HDR,
        CAP_CAP,
        CAP_DONE
    } cap_state_t;
endpackage

// File: rtl/ts_pid_filter.sv
// ts_pid_filter: programmable PID table with a parallel compare.
//   clk, rst_n   : clock, async active-low reset (table cleared = all slots disabled)
//   i_wr_en      : write strobe for slot i_index
//   i_index      : slot index for both write and readback; out-of-range is ignored / reads 0
//   i_wr_pid     : [12:0] PID, [16] enable; other bits ignored
//   o_rd_pid     : combinational readback of slot i_index in the same layout
//   i_pid        : PID to look up
//   o_hit        : any enabled slot equals i_pid
module ts_pid_filter
    import ts_pkg::*;
#(
    parameter int MATCH_PID_COUNT = 4,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_index,
    input  logic [DATA_W-1:0] i_wr_pid,
    output logic [DATA_W-1:0] o_rd_pid,
    input  logic [PID_W-1:0]  i_pid,
    output logic              o_hit
);
    localparam int IDX_W = (MATCH_PID_COUNT > 1) ? $clog2(MATCH_PID_COUNT) : 1;

    logic [MATCH_PID_COUNT-1:0][PID_W-1:0] r_pid;
    logic [MATCH_PID_COUNT-1:0]            r_en;
    logic [MATCH_PID_COUNT-1:0]            w_slot_hit;
    logic                                  w_in_range;
    logic [IDX_W-1:0]                      w_idx;
    logic                                  w_unused_bits;

    // Full-width compare so that large indices never alias onto a real slot.
    assign w_in_range    = (i_index < DATA_W'(MATCH_PID_COUNT));
    assign w_idx         = i_index[IDX_W-1:0];
    assign w_unused_bits = ^{i_wr_pid[DATA_W-1:PID_EN_BIT+1], i_wr_pid[PID_EN_BIT-1:PID_MSB+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pid <= '0;
            r_en  <= '0;
        end else if (i_wr_en && w_in_range) begin
            r_pid[w_idx] <= i_wr_pid[PID_MSB:PID_LSB];
            r_en[w_idx]  <= i_wr_pid[PID_EN_BIT];
        end
    end

    for (genvar s = 0; s < MATCH_PID_COUNT; s++) begin : g_slot
        assign w_slot_hit[s] = r_en[s] && (r_pid[s] == i_pid);
    end

    // Several matching slots collapse to a single hit.
    assign o_hit = |w_slot_hit;

    always_comb begin
        o_rd_pid = '0;
        if (w_in_range) begin
            o_rd_pid[PID_MSB:PID_LSB] = r_pid[w_idx];
            o_rd_pid[PID_EN_BIT]      = r_en[w_idx];
        end
    end
endmodule

// File: rtl/ts_pid_capture.sv
// ts_pid_capture: watches a 188-byte MPEG-TS byte stream, filters packets by PID and
// captures up to CAPTURE_GROUPS whole matching packets into a word-packed buffer.
//   clk, rst_n                      : clock, async active-low reset
//   mpeg_data/valid/sync            : TS byte stream; sync marks byte 0 (with data 0x47)
//   update_pid_request, pid_index,
//   pid, out_pid                    : PID table write / combinational readback
//   capture_request                 : arms a capture run (ignored while busy)
//   capture_busy, capture_ready     : run armed/capturing, run complete
//   captured_count                  : packets stored in the current/last run
//   read_index, read_data           : buffer word read, one cycle latency, 0 when out of range
//   matched_count                   : free-running count of PID hits
// Packet byte n of group g lands in word g*47+n/4, bits [8*(n%4)+7 -: 8].
module ts_pid_capture
    import ts_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MATCH_PID_COUNT    = 4,
    parameter int CAPTURE_GROUPS     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    mpeg_data,
    input  logic                          mpeg_valid,
    input  logic                          mpeg_sync,
    input  logic                          update_pid_request,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] pid_index,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] pid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] out_pid,
    input  logic                          capture_request,
    output logic                          capture_busy,
    output logic                          capture_ready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] captured_count,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] read_index,
    output logic [C_S_AXI_DATA_WIDTH-1:0] read_data,
    output logic [C_S_AXI_DATA_WIDTH-1:0] matched_count
);
    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int BUF_WORDS = TS_PACK_WORD_SIZE * CAPTURE_GROUPS;
    localparam int ADDR_W    = $clog2(BUF_WORDS);

    cap_state_t     r_state;
    logic [7:0]     r_next_idx;
    logic [4:0]     r_pid_hi;
    logic [DW-1:0]  r_word;
    logic [DW-1:0]  r_captured_count;
    logic [DW-1:0]  r_matched_count;
    logic [DW-1:0]  r_read_data;
    logic           r_busy;
    logic           r_ready;
    logic [DW-1:0]  r_mem [BUF_WORDS];

    logic              w_sync;
    logic [7:0]        w_cur_idx;
    logic              w_byte_ok;
    logic              w_pid_byte;
    logic              w_hit;
    logic              w_last_byte;
    logic              w_store;
    logic              w_word_wr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DW-1:0]     w_wr_data;
    logic [DW-1:0]     w_count_inc;

    ts_pid_filter #(
        .MATCH_PID_COUNT (MATCH_PID_COUNT),
        .DATA_W          (DW)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr_en  (update_pid_request),
        .i_index  (pid_index),
        .i_wr_pid (pid),
        .o_rd_pid (out_pid),
        .i_pid    ({r_pid_hi, mpeg_data}),
        .o_hit    (w_hit)
    );

    // Index of the byte currently on the bus; 188 means "outside any packet".
    assign w_sync      = mpeg_valid && mpeg_sync && (mpeg_data == TS_SYNC_BYTE);
    assign w_cur_idx   = w_sync ? 8'd0 : r_next_idx;
    assign w_byte_ok   = mpeg_valid && (w_cur_idx < 8'(TS_PACK_BYTE_SIZE));
    assign w_pid_byte  = w_byte_ok && (w_cur_idx == 8'd2);
    assign w_last_byte = w_byte_ok && (w_cur_idx == 8'(TS_PACK_BYTE_SIZE - 1));
    assign w_count_inc = r_captured_count + DW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_idx <= 8'(TS_PACK_BYTE_SIZE);
            r_pid_hi   <= '0;
        end else if (mpeg_valid) begin
            r_next_idx <= w_byte_ok ? w_cur_idx + 8'd1 : 8'(TS_PACK_BYTE_SIZE);
            if (w_byte_ok && w_cur_idx == 8'd1)
                r_pid_hi <= mpeg_data[4:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_matched_count <= '0;
        else if (w_pid_byte && w_hit)
            r_matched_count <= r_matched_count + DW'(1);
    end

    // Header bytes are stored speculatively; a miss simply lets the next packet reuse the slot.
    always_comb begin
        w_store = 1'b0;
        case (r_state)
            CAP_ARMED:        w_store = w_sync;
            CAP_HDR, CAP_CAP: w_store = w_byte_ok;
            default:          w_store = 1'b0;
        endcase
    end

    assign w_word_wr = w_store && (w_cur_idx[1:0] == 2'd3);
    assign w_wr_data = {mpeg_data, r_word[DW-1:8]};
    assign w_wr_addr = ADDR_W'(r_captured_count * DW'(TS_PACK_WORD_SIZE) + DW'(w_cur_idx[7:2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_word <= '0;
        else if (w_store)
            r_word <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= CAP_IDLE;
            r_captured_count <= '0;
            r_busy           <= 1'b0;
            r_ready          <= 1'b0;
        end else begin
            case (r_state)
                CAP_IDLE: begin
                    if (capture_request) begin
                        r_state          <= CAP_ARMED;
                        r_captured_count <= '0;
                        r_ready          <= 1'b0;
                        r_busy           <= 1'b1;
                    end
                end
                CAP_ARMED: begin
                    if (w_sync)
                        r_state <= CAP_HDR;
                end
                CAP_HDR: begin
                    // A fresh sync here restarts at byte 0 and stays in HDR.
                    if (w_pid_byte)
                        r_state <= w_hit ? CAP_CAP : CAP_ARMED;
                end
                CAP_CAP: begin
                    if (w_sync) begin
                        r_state <= CAP_HDR;
                    end else if (w_last_byte) begin
                        r_captured_count <= w_count_inc;
                        r_state <= (w_count_inc == DW'(CAPTURE_GROUPS)) ? CAP_DONE : CAP_ARMED;
                    end
                end
                CAP_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= CAP_IDLE;
                end
                default: r_state <= CAP_IDLE;
            endcase
        end
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_word_wr)
            r_mem[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_read_data <= '0;
        else if (read_index < DW'(BUF_WORDS))
            r_read_data <= r_mem[read_index[ADDR_W-1:0]];
        else
            r_read_data <= '0;
    end

    assign capture_busy   = r_busy;
    assign capture_ready  = r_ready;
    assign captured_count = r_captured_count;
    assign matched_count  = r_matched_count;
    assign read_data      = r_read_data;
endmodule
